// File: rtl/avalon_memory_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM among NUM_REQ Avalon-style requesters.
// It grants one command per cycle, routes read responses through a tag pipeline and holds back read-after-write hazards.
module avalon_memory_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int BUSWIDTH     = 32,
    parameter int ADDRESSWIDTH = 8,
    parameter int LATENCY      = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_read_i,
    input  logic [NUM_REQ-1:0]              req_write_i,
    input  logic [NUM_REQ*ADDRESSWIDTH-1:0] req_address_i,
    input  logic [NUM_REQ*BUSWIDTH-1:0]     req_data_in_i,
    output logic [NUM_REQ-1:0]              req_waitrequest_o,
    output logic [NUM_REQ-1:0]              req_read_valid_o,
    output logic [BUSWIDTH-1:0]             req_data_out_o,
    output logic                            mem_read_o,
    output logic                            mem_write_o,
    output logic [ADDRESSWIDTH-1:0]         mem_address_o,
    output logic [BUSWIDTH-1:0]             mem_data_in_o,
    input  logic [BUSWIDTH-1:0]             mem_data_out_i
);

    localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [IDW-1:0]          last_grant_q;
    logic                    wr_last_q;
    logic [ADDRESSWIDTH-1:0] wr_addr_q;
    logic [ADDRESSWIDTH-1:0] addr_hold_q;
    logic [BUSWIDTH-1:0]     data_hold_q;
    logic [LATENCY-1:0]      tag_vld_q;
    logic [IDW-1:0]          tag_id_q [LATENCY];

    logic [ADDRESSWIDTH-1:0] addr_arr [NUM_REQ];
    logic [BUSWIDTH-1:0]     data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]      active;
    logic [NUM_REQ-1:0]      eligible;
    logic [NUM_REQ-1:0]      gnt_oh;
    logic                    gnt_vld;
    logic [IDW-1:0]          gnt_id;
    logic                    sel_write;
    logic                    sel_read;

    // A read-only request to the address written last cycle sits out one cycle; writes are never masked.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr[i] = req_address_i[i*ADDRESSWIDTH +: ADDRESSWIDTH];
            data_arr[i] = req_data_in_i[i*BUSWIDTH +: BUSWIDTH];
            active[i]   = req_read_i[i] | req_write_i[i];
            eligible[i] = active[i] &
                          ~(req_read_i[i] & ~req_write_i[i] & wr_last_q &
                            (addr_arr[i] == wr_addr_q));
        end
    end

    always_comb begin : rr_search
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!gnt_vld && eligible[IDW'(idx)]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'(idx);
            end
        end
        if (reset) begin
            gnt_vld = 1'b0;
        end
    end

    always_comb begin
        sel_write = req_write_i[gnt_id];
        sel_read  = req_read_i[gnt_id] & ~sel_write;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_oh[i] = gnt_vld && (gnt_id == IDW'(i));
        end
        mem_write_o   = gnt_vld & sel_write;
        mem_read_o    = gnt_vld & sel_read;
        mem_address_o = gnt_vld ? addr_arr[gnt_id] : addr_hold_q;
        mem_data_in_o = gnt_vld ? data_arr[gnt_id] : data_hold_q;
        req_waitrequest_o = reset ? {NUM_REQ{1'b1}} : (active & ~gnt_oh);
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_read_valid_o[i] = tag_vld_q[LATENCY-1] && (tag_id_q[LATENCY-1] == IDW'(i));
        end
        req_data_out_o = mem_data_out_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= IDW'(NUM_REQ - 1);
            wr_last_q    <= 1'b0;
            wr_addr_q    <= '0;
            addr_hold_q  <= '0;
            data_hold_q  <= '0;
            tag_vld_q    <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            if (gnt_vld) begin
                last_grant_q <= gnt_id;
                addr_hold_q  <= mem_address_o;
                data_hold_q  <= mem_data_in_o;
            end
            wr_last_q <= mem_write_o;
            if (mem_write_o) begin
                wr_addr_q <= mem_address_o;
            end
            tag_vld_q[0] <= mem_read_o;
            tag_id_q[0]  <= gnt_id;
            for (int s = 1; s < LATENCY; s++) begin
                tag_vld_q[s] <= tag_vld_q[s-1];
                tag_id_q[s]  <= tag_id_q[s-1];
            end
        end
    end

endmodule
